regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 Parameter PEND_W, default 2: width of each per-register pending-write counter.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-006 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-007 CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-008 RESET  in  1  asynchronous, active-low reset.
REQ-009 ReadRegister_IN  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 ReadData_OUT  out  NUM_RD*DATA_W  read data, packed in the same order.
REQ-011 ReadBusy_OUT  out  NUM_RD  per port: the addressed register still has an outstanding producer.
REQ-012 WriteData_IN / WriteRegister_IN / WriteEnable_IN  in  DATA_W / ADDR_W / 1  write-back port.
REQ-013 IssueRegister_IN / IssueEnable_IN  in  ADDR_W / 1  a producer of IssueRegister_IN enters the pipeline.
REQ-014 write_OUT / WBRegisterValue_OUT / WBRegister_OUT  out  1 / DATA_W / ADDR_W  registered write-back snoop.
REQ-015 Overflow_OUT  out  1  sticky flag: an issue hit a saturated pending counter.

Function
REQ-016 Read data SHALL be combinational: Reg[addr], or zero when ZERO_REG=1 and addr=0.
REQ-017 With BYPASS=1, a read port whose address equals WriteRegister_IN while WriteEnable_IN=1 SHALL return WriteData_IN in the same cycle; register 0 is excluded when ZERO_REG=1.
REQ-018 A write SHALL update Reg[WriteRegister_IN] at the rising edge; with ZERO_REG=1, writes to register 0 SHALL be discarded.
REQ-019 Each register SHALL own a PEND_W-bit pending counter, updated at the edge as follows: issue only, +1; write only, -1; both or neither, unchanged.
REQ-020 At the maximum value the counter SHALL hold on issue, and Overflow_OUT SHALL set and stay set until reset.
REQ-021 A write to a register whose counter is 0 SHALL leave the counter at 0 (no underflow); the data write still occurs.
REQ-022 ReadBusy_OUT[k] SHALL equal (count[addr] - hit) != 0, where hit=1 only when BYPASS=1 and a same-cycle write targets addr; it SHALL be 0 when ZERO_REG=1 and addr=0.
REQ-023 Issue and write in the same cycle to different registers SHALL update both counters independently.
REQ-024 write_OUT SHALL be 1 for exactly the one cycle after each accepted write edge and 0 otherwise; discarded register-0 writes produce no pulse.
REQ-025 WBRegisterValue_OUT / WBRegister_OUT SHALL load at each accepted write edge and hold between writes.

Reset
REQ-026 RESET low SHALL immediately clear all registers, all counters, write_OUT, WBRegisterValue_OUT, WBRegister_OUT and Overflow_OUT, regardless of CLOCK.
REQ-027 Writes and issues presented while RESET is low SHALL be ignored; the first accepted edge is the first rising edge with RESET high.

Structure
REQ-028 Package regfile_pkg SHALL hold the parameter defaults and a helper constant for the counter maximum, (2**PEND_W)-1.
REQ-029 Sub-module pend_counter (saturating up/down counter with overflow strobe) SHALL be instantiated once per register via generate.
REQ-030 Storage SHALL be a single clocked array; no negedge logic anywhere.

Verification
REQ-031 Write 0xDEADBEEF to r5, then read r5 on port 0 and port 1 next cycle -> both read 0xDEADBEEF; one cycle after the edge, write_OUT=1, WBRegister_OUT=5, WBRegisterValue_OUT=0xDEADBEEF; write_OUT=0 the cycle after.
REQ-032 Write 0x12345678 to r7 while port 1 reads r7 in the same cycle -> ReadData port 1 = 0x12345678 with BYPASS=1; old value with BYPASS=0.
REQ-033 Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> r0 reads 0, no write_OUT pulse, ReadBusy=0 after an issue to r0.
REQ-034 Issue r3 three times (PEND_W=2) -> count 3, ReadBusy=1; a fourth issue -> Overflow_OUT=1 and count stays 3; three writes -> ReadBusy=0, with ReadBusy=0 already in the cycle of the third write when BYPASS=1.
REQ-035 Issue and write r9 in the same cycle from count 1 -> count remains 1; a write with count 0 -> count 0 and data updated.
REQ-036 Assert RESET low mid-cycle with pending counts and a write_OUT pulse active -> all outputs 0 immediately; a write attempted during reset is not stored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Holds parameter defaults and the pending-counter maximum helper.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int PEND_W_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;
  localparam int BYPASS_DEF   = 1;

  function automatic int pend_max(input int w);
    return (2 ** w) - 1;
  endfunction

  localparam int PEND_MAX_DEF = pend_max(PEND_W_DEF);

endpackage

// File: rtl/regfile_sb_pend_counter.sv
// Saturating up/down pending-write counter with overflow strobe.
// Ports: i_clk, i_rst_n, i_inc, i_dec -> o_count, o_ovf (comb strobe).
module pend_counter
  import regfile_pkg::*;
#(
  parameter int W = PEND_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAX = W'(pend_max(W));

  logic [W-1:0] r_count;

  // Simultaneous inc and dec cancel, so only a lone inc can overflow.
  assign o_ovf   = i_inc && !i_dec && (r_count == MAX);
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_count != MAX) r_count <= r_count + 1'b1;
    end else if (!i_inc && i_dec) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard.
// Ports: CLOCK, RESET (async low), read ports, write-back, issue, snoop, Overflow_OUT.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PEND_W   = PEND_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] ReadRegister_IN,
  output logic [NUM_RD*DATA_W-1:0] ReadData_OUT,
  output logic [NUM_RD-1:0]        ReadBusy_OUT,
  input  logic [DATA_W-1:0]        WriteData_IN,
  input  logic [ADDR_W-1:0]        WriteRegister_IN,
  input  logic                     WriteEnable_IN,
  input  logic [ADDR_W-1:0]        IssueRegister_IN,
  input  logic                     IssueEnable_IN,
  output logic                     write_OUT,
  output logic [DATA_W-1:0]        WBRegisterValue_OUT,
  output logic [ADDR_W-1:0]        WBRegister_OUT,
  output logic                     Overflow_OUT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wb;
  logic [DATA_W-1:0] r_wb_val;
  logic [ADDR_W-1:0] r_wb_reg;
  logic              r_ovf;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [PEND_W-1:0] w_cnt [DEPTH];
  logic [DEPTH-1:0]  w_ovf;

  // Register 0 is hardwired when ZERO_REG: drop its writes and issues.
  assign w_wr_ok  = WriteEnable_IN &&
                    !(ZERO_REG != 0 && WriteRegister_IN == '0);
  assign w_iss_ok = IssueEnable_IN &&
                    !(ZERO_REG != 0 && IssueRegister_IN == '0);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[WriteRegister_IN] <= WriteData_IN;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    pend_counter #(.W(PEND_W)) u_pc (
      .i_clk   (CLOCK),
      .i_rst_n (RESET),
      .i_inc   (w_iss_ok && IssueRegister_IN == ADDR_W'(g)),
      .i_dec   (w_wr_ok && WriteRegister_IN == ADDR_W'(g)),
      .o_count (w_cnt[g]),
      .o_ovf   (w_ovf[g])
    );
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_hit;
    logic [PEND_W-1:0] w_left;

    assign w_addr = ReadRegister_IN[k*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_hit  = (BYPASS != 0) && w_wr_ok &&
                    (WriteRegister_IN == w_addr);
    // Modular difference: a hit on an idle counter still reads busy.
    assign w_left = w_cnt[w_addr] - PEND_W'(w_hit);

    assign ReadData_OUT[k*DATA_W +: DATA_W] =
      w_zero ? '0 :
      w_hit  ? WriteData_IN : r_mem[w_addr];
    assign ReadBusy_OUT[k] = !w_zero && (w_left != '0);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wb     <= 1'b0;
      r_wb_val <= '0;
      r_wb_reg <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wb <= w_wr_ok;
      if (w_wr_ok) begin
        r_wb_val <= WriteData_IN;
        r_wb_reg <= WriteRegister_IN;
      end
      if (|w_ovf) r_ovf <= 1'b1;
    end
  end

  assign write_OUT           = r_wb;
  assign WBRegisterValue_OUT = r_wb_val;
  assign WBRegister_OUT      = r_wb_reg;
  assign Overflow_OUT        = r_ovf;

endmodule
